// File: rtl/store_trace_checker_if.sv
// Bundle of table-load, control, observed store bus and status signals
// shared between store_trace_checker and the bench that drives it.
interface store_trace_checker_if #(
    parameter int IDX_W = 4
);
    // Expected-store table load port
    logic              load_en;
    logic [IDX_W-1:0]  load_idx;
    logic [31:0]       load_addr;
    logic [31:0]       load_data;

    // Run control
    logic              start;
    logic [IDX_W:0]    expect_count;

    // Processor data-memory write port being monitored
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;

    // Status
    logic              busy;
    logic              done;
    logic              pass;
    logic [IDX_W:0]    err_index;
    logic [31:0]       err_addr;
    logic [31:0]       err_data;
    logic [15:0]       cycles;

    // Checker side
    modport slave (
        input  load_en, load_idx, load_addr, load_data,
        input  start, expect_count,
        input  mem_write, mem_addr, mem_wdata,
        output busy, done, pass, err_index, err_addr, err_data, cycles
    );

    // Driver / bench side
    modport master (
        output load_en, load_idx, load_addr, load_data,
        output start, expect_count,
        output mem_write, mem_addr, mem_wdata,
        input  busy, done, pass, err_index, err_addr, err_data, cycles
    );
endinterface

// File: rtl/store_trace_checker.sv
// Store trace checker: compares each processor store against an in-order
// table of expected {address, data} pairs and reports PASS, the first
// mismatch (FAIL), or TIMEOUT. All status outputs are registered.
module store_trace_checker #(
    parameter int N_EXPECT = 16,
    parameter int IDX_W    = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    store_trace_checker_if.slave  bus
);

    localparam int unsigned CW           = IDX_W + 1;
    localparam logic [CW-1:0] COUNT_MAX  = CW'(N_EXPECT);
    localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    cyc_q, cyc_d;
    logic [CW-1:0]  err_index_q, err_index_d;
    logic [31:0]    err_addr_q, err_addr_d;
    logic [31:0]    err_data_q, err_data_d;
    logic           busy_q, done_q, pass_q;

    // Expected-store table; deliberately not reset so it survives reset/restart
    logic [31:0]    tab_addr_q [N_EXPECT];
    logic [31:0]    tab_data_q [N_EXPECT];

    logic [IDX_W-1:0] rd_idx;
    logic             entry_hit;
    logic             last_entry;
    logic [CW-1:0]    count_clamped;
    logic             load_ok;

    assign rd_idx        = idx_q[IDX_W-1:0];
    assign entry_hit     = (bus.mem_addr  == tab_addr_q[rd_idx]) &&
                           (bus.mem_wdata == tab_data_q[rd_idx]);
    assign last_entry    = (idx_q == (count_q - CW'(1)));
    assign count_clamped = (bus.expect_count > COUNT_MAX) ? COUNT_MAX
                                                          : bus.expect_count;
    assign load_ok       = bus.load_en && (state_q != S_RUN) &&
                           (int'(bus.load_idx) < N_EXPECT);

    // Table write port, blocked while a check is running
    always_ff @(posedge clk) begin
        if (load_ok) begin
            tab_addr_q[bus.load_idx] <= bus.load_addr;
            tab_data_q[bus.load_idx] <= bus.load_data;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        cyc_d       = cyc_q;
        err_index_d = err_index_q;
        err_addr_d  = err_addr_q;
        err_data_d  = err_data_q;

        case (state_q)
            S_RUN: begin
                cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
                if (bus.mem_write && entry_hit && last_entry) begin
                    // Completing match wins over a simultaneous timeout
                    state_d = S_PASS;
                end else if (bus.mem_write && !entry_hit) begin
                    // Mismatch also wins over a simultaneous timeout
                    state_d     = S_FAIL;
                    err_index_d = idx_q;
                    err_addr_d  = bus.mem_addr;
                    err_data_d  = bus.mem_wdata;
                end else begin
                    if (bus.mem_write) begin
                        idx_d = idx_q + CW'(1);
                    end
                    if (cyc_q == TIMEOUT_LAST) begin
                        // Report the number of stores matched so far,
                        // including a non-final match in this same cycle
                        state_d     = S_TIMEOUT;
                        err_index_d = idx_d;
                    end
                end
            end
            default: begin
                // IDLE and all done states accept a (re)start
                if (bus.start) begin
                    count_d     = count_clamped;
                    idx_d       = '0;
                    cyc_d       = '0;
                    err_index_d = '0;
                    err_addr_d  = '0;
                    err_data_d  = '0;
                    state_d     = (count_clamped == '0) ? S_PASS : S_RUN;
                end
            end
        endcase
    end

    // State, datapath and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            count_q     <= '0;
            cyc_q       <= '0;
            err_index_q <= '0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            cyc_q       <= cyc_d;
            err_index_q <= err_index_d;
            err_addr_q  <= err_addr_d;
            err_data_q  <= err_data_d;
            busy_q      <= (state_d == S_RUN);
            done_q      <= (state_d == S_PASS) || (state_d == S_FAIL) ||
                           (state_d == S_TIMEOUT);
            pass_q      <= (state_d == S_PASS);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_index = err_index_q;
    assign bus.err_addr  = err_addr_q;
    assign bus.err_data  = err_data_q;
    assign bus.cycles    = cyc_q;

endmodule

// File: tb/tb_store_trace_checker.sv
// Bench for store_trace_checker: a behavioural model predicts the outcome of
// each run when it is started; the prediction is queued and popped once the
// checker reports done.
module tb_store_trace_checker;

    localparam int TO    = 20;
    localparam int NE    = 16;
    localparam int MAXK  = 64;

    typedef struct packed {
        logic        pass;
        logic [4:0]  err_index;
        logic [31:0] err_addr;
        logic [31:0] err_data;
        logic [15:0] cycles;
    } result_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_trace_checker_if #(.IDX_W(4)) bus ();

    store_trace_checker #(
        .N_EXPECT (NE),
        .IDX_W    (4),
        .TIMEOUT  (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    result_t     exp_q [$];
    logic [31:0] m_addr [NE];
    logic [31:0] m_data [NE];
    logic        sched_we   [MAXK];
    logic [31:0] sched_addr [MAXK];
    logic [31:0] sched_data [MAXK];
    logic        run_expired;
    logic        busy_after_start;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int k = 0; k < MAXK; k++) begin
            sched_we[k]   = 1'b0;
            sched_addr[k] = '0;
            sched_data[k] = '0;
        end
    endtask

    task automatic add_store(input int k, input logic [31:0] a, input logic [31:0] d);
        sched_we[k]   = 1'b1;
        sched_addr[k] = a;
        sched_data[k] = d;
    endtask

    task automatic load_entry(input int i, input logic [31:0] a, input logic [31:0] d);
        bus.load_en   = 1'b1;
        bus.load_idx  = 4'(i);
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_en   = 1'b0;
        m_addr[i] = a;
        m_data[i] = d;
    endtask

    // Behavioural walk of the schedule against the bench's copy of the table
    function automatic result_t predict(input int count);
        result_t r;
        int cnt;
        int idx;
        r   = '0;
        cnt = (count > NE) ? NE : count;
        idx = 0;
        if (cnt == 0) begin
            r.pass = 1'b1;
            return r;
        end
        for (int k = 0; k < MAXK; k++) begin
            if (sched_we[k]) begin
                if (sched_addr[k] == m_addr[idx] && sched_data[k] == m_data[idx]) begin
                    if (idx == cnt - 1) begin
                        r.pass   = 1'b1;
                        r.cycles = 16'(k + 1);
                        return r;
                    end
                    idx++;
                end else begin
                    r.err_index = 5'(idx);
                    r.err_addr  = sched_addr[k];
                    r.err_data  = sched_data[k];
                    r.cycles    = 16'(k + 1);
                    return r;
                end
            end
            if (k == TO - 1) begin
                r.err_index = 5'(idx);
                r.cycles    = 16'(k + 1);
                return r;
            end
        end
        return r;
    endfunction

    // Start a run (optionally with a same-cycle table write), queue the
    // prediction, then play the schedule until done or the cycle bound.
    task automatic run_checker(input int count, input bit co_load, input int li,
                               input logic [31:0] la, input logic [31:0] ld);
        int k;
        bus.start        = 1'b1;
        bus.expect_count = 5'(count);
        if (co_load) begin
            bus.load_en   = 1'b1;
            bus.load_idx  = 4'(li);
            bus.load_addr = la;
            bus.load_data = ld;
            m_addr[li] = la;
            m_data[li] = ld;
        end
        exp_q.push_back(predict(count));
        tick();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        busy_after_start = bus.busy;
        run_expired = 1'b0;
        k = 0;
        while (bus.done !== 1'b1) begin
            if (k >= MAXK) begin
                run_expired = 1'b1;
                break;
            end
            bus.mem_write = sched_we[k];
            bus.mem_addr  = sched_addr[k];
            bus.mem_wdata = sched_data[k];
            tick();
            k++;
        end
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
    endtask

    function automatic result_t observed();
        result_t r;
        r.pass      = bus.pass;
        r.err_index = bus.err_index;
        r.err_addr  = bus.err_addr;
        r.err_data  = bus.err_data;
        r.cycles    = bus.cycles;
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got busy/done/pass=%b want 000", {bus.busy, bus.done, bus.pass});
        end
        checks++;
        if (observed() !== result_t'('0)) begin
            failures++;
            $display("FAIL reset_values got idx=%0d addr=%0h data=%0h cyc=%0d want all 0",
                     bus.err_index, bus.err_addr, bus.err_data, bus.cycles);
        end
    endtask

    task automatic test_pass();
        result_t e;
        clear_sched();
        add_store(2, 32'h10, 32'hFEFE);
        add_store(5, 32'h14, 32'h1);
        add_store(6, 32'h18, 32'h2);
        run_checker(3, 1'b1, 2, 32'h18, 32'h2);
        e = exp_q.pop_front();
        checks++;
        if (busy_after_start !== 1'b1) begin
            failures++;
            $display("FAIL pass_busy got %b want 1", busy_after_start);
        end
        checks++;
        if (run_expired || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL pass_done got done=%b expired=%b want done=1", bus.done, run_expired);
        end
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL pass_result got p=%b idx=%0d cyc=%0d want p=%b idx=%0d cyc=%0d",
                     bus.pass, bus.err_index, bus.cycles, e.pass, e.err_index, e.cycles);
        end
        checks++;
        if (bus.cycles !== 16'd7) begin
            failures++;
            $display("FAIL pass_cycles got %0d want 7", bus.cycles);
        end
    endtask

    task automatic test_mismatch();
        result_t e;
        clear_sched();
        add_store(2, 32'h10, 32'hFEFE);
        add_store(5, 32'h14, 32'h3);
        run_checker(3, 1'b0, 0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (run_expired || bus.done !== 1'b1 || observed() !== e) begin
            failures++;
            $display("FAIL mismatch_result got p=%b idx=%0d a=%0h d=%0h cyc=%0d want p=%b idx=%0d a=%0h d=%0h cyc=%0d",
                     bus.pass, bus.err_index, bus.err_addr, bus.err_data, bus.cycles,
                     e.pass, e.err_index, e.err_addr, e.err_data, e.cycles);
        end
        // Further stores after completion must not disturb the report
        bus.mem_write = 1'b1;
        bus.mem_addr  = 32'hBAD0;
        bus.mem_wdata = 32'hBAD1;
        tick();
        tick();
        bus.mem_write = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || observed() !== e) begin
            failures++;
            $display("FAIL mismatch_hold got done=%b a=%0h d=%0h cyc=%0d want done=1 a=%0h d=%0h cyc=%0d",
                     bus.done, bus.err_addr, bus.err_data, bus.cycles, e.err_addr, e.err_data, e.cycles);
        end
    endtask

    task automatic test_timeout();
        result_t e;
        clear_sched();
        add_store(2, 32'h10, 32'hFEFE);
        run_checker(2, 1'b0, 0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (run_expired || bus.done !== 1'b1 || observed() !== e) begin
            failures++;
            $display("FAIL timeout_result got p=%b idx=%0d cyc=%0d want p=%b idx=%0d cyc=%0d",
                     bus.pass, bus.err_index, bus.cycles, e.pass, e.err_index, e.cycles);
        end
    endtask

    task automatic test_zero_count();
        result_t e;
        clear_sched();
        run_checker(0, 1'b0, 0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (busy_after_start !== 1'b0 || bus.done !== 1'b1 || observed() !== e) begin
            failures++;
            $display("FAIL zero_count got busy=%b done=%b p=%b cyc=%0d want busy=0 done=1 p=%b cyc=%0d",
                     busy_after_start, bus.done, bus.pass, bus.cycles, e.pass, e.cycles);
        end
    endtask

    task automatic test_timeout_race();
        result_t e;
        clear_sched();
        add_store(TO - 1, 32'h10, 32'hFEFE);
        run_checker(1, 1'b0, 0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (run_expired || observed() !== e) begin
            failures++;
            $display("FAIL race_match got p=%b idx=%0d cyc=%0d want p=%b idx=%0d cyc=%0d",
                     bus.pass, bus.err_index, bus.cycles, e.pass, e.err_index, e.cycles);
        end
        clear_sched();
        add_store(TO - 1, 32'h10, 32'h0);
        run_checker(1, 1'b0, 0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (run_expired || observed() !== e) begin
            failures++;
            $display("FAIL race_mismatch got p=%b idx=%0d d=%0h cyc=%0d want p=%b idx=%0d d=%0h cyc=%0d",
                     bus.pass, bus.err_index, bus.err_data, bus.cycles, e.pass, e.err_index, e.err_data, e.cycles);
        end
    endtask

    task automatic test_reset_mid_run();
        result_t e;
        bus.start        = 1'b1;
        bus.expect_count = 5'd3;
        tick();
        bus.start     = 1'b0;
        bus.mem_write = 1'b1;
        bus.mem_addr  = 32'h10;
        bus.mem_wdata = 32'hFEFE;
        tick();
        bus.mem_write = 1'b0;
        // Table write during RUN must be ignored
        bus.load_en   = 1'b1;
        bus.load_idx  = 4'd0;
        bus.load_addr = 32'hDEAD;
        bus.load_data = 32'hBEEF;
        tick();
        bus.load_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00 || bus.cycles !== 16'd0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b done=%b cyc=%0d want busy=0 done=0 cyc=0",
                     bus.busy, bus.done, bus.cycles);
        end
        clear_sched();
        add_store(0, 32'h10, 32'hFEFE);
        add_store(1, 32'h14, 32'h1);
        add_store(2, 32'h18, 32'h2);
        run_checker(3, 1'b0, 0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (run_expired || observed() !== e) begin
            failures++;
            $display("FAIL midrun_restart got p=%b idx=%0d a=%0h cyc=%0d want p=%b idx=%0d a=%0h cyc=%0d",
                     bus.pass, bus.err_index, bus.err_addr, bus.cycles, e.pass, e.err_index, e.err_addr, e.cycles);
        end
    endtask

    task automatic test_clamp();
        result_t e;
        clear_sched();
        for (int i = 0; i < NE; i++) begin
            load_entry(i, 32'h100 + 32'(4 * i), $urandom);
        end
        for (int i = 0; i < NE; i++) begin
            add_store(i, m_addr[i], m_data[i]);
        end
        run_checker(31, 1'b0, 0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (run_expired || observed() !== e) begin
            failures++;
            $display("FAIL clamp_count got p=%b idx=%0d cyc=%0d want p=%b idx=%0d cyc=%0d",
                     bus.pass, bus.err_index, bus.cycles, e.pass, e.err_index, e.cycles);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.load_en      = 1'b0;
        bus.load_idx     = '0;
        bus.load_addr    = '0;
        bus.load_data    = '0;
        bus.start        = 1'b0;
        bus.expect_count = '0;
        bus.mem_write    = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        for (int i = 0; i < NE; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
        end
        #1;
        test_reset();
        load_entry(0, 32'h10, 32'hFEFE);
        load_entry(1, 32'h14, 32'h1);
        test_pass();
        test_mismatch();
        test_timeout();
        test_zero_count();
        test_timeout_race();
        test_reset_mid_run();
        test_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_trace_checker.md
# store_trace_checker

Self-checking monitor that sits directly downstream of the single-cycle processor's data-memory write port in the processor-level benches. It holds a table of expected stores (address/data pairs) and compares each processor store against the next expected entry, in order. It reports pass, first mismatch, or timeout to the enclosing testbench, replacing hand-written per-instruction waveform checks with one reusable synthesizable block.

## Interface
Parameters:
- N_EXPECT, 16: depth of expected-store table.
- IDX_W, 4: index width. Must equal clog2(N_EXPECT).
- TIMEOUT, 1024: maximum RUN cycles before declaring timeout. Must be 1..65535.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write one table entry this cycle. Honoured only in IDLE or done states.
- load_idx  in  IDX_W  table entry to write.
- load_addr  in  32  expected store address.
- load_data  in  32  expected store data.
- start  in  1  begin checking. Honoured in IDLE or done states.
- expect_count  in  IDX_W+1  number of stores to check, 0..N_EXPECT. Sampled on start.
- mem_write  in  1  processor data-memory write enable.
- mem_addr  in  32  processor store address.
- mem_wdata  in  32  processor store data.
- busy  out  1  high in RUN.
- done  out  1  high in PASS, FAIL or TIMEOUT.
- pass  out  1  high only in PASS.
- err_index  out  IDX_W+1  index of the failing entry. In TIMEOUT, the number of stores matched.
- err_addr  out  32  mem_addr captured at the mismatch; 0 otherwise.
- err_data  out  32  mem_wdata captured at the mismatch; 0 otherwise.
- cycles  out  16  RUN cycle count, saturating at 16'hFFFF.

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. The state register is the only source of busy, done and pass; all outputs are registered.
- Reset (synchronous):
  - State goes to IDLE.
  - busy, done, pass = 0; err_index, err_addr, err_data, cycles = 0.
  - Match index = 0; latched count = 0.
  - Table contents are NOT cleared.
- IDLE or done state, start=1:
  - Latch expect_count.
  - Clear the match index, cycles and err_* outputs.
  - If expect_count == 0, go to PASS; otherwise go to RUN.
- RUN, each cycle:
  - cycles increments, saturating.
  - If mem_write=1, compare {mem_addr, mem_wdata} against entry[idx].
  - Match with idx == count-1: go to PASS.
  - Match otherwise: idx++.
  - Mismatch: go to FAIL; err_index = idx; capture err_addr and err_data.
  - mem_write=0: no comparison.
- Timeout: in RUN, if cycles reaches TIMEOUT-1 and no completing match occurs in that cycle, go to TIMEOUT with err_index = idx.
- Done states hold all outputs until reset or start. Further mem_write activity is ignored.
- load_en while busy is ignored; the table is not modified.
- Both comparison fields must match exactly: all 32 address bits and all 32 data bits.
- expect_count > N_EXPECT is clamped to N_EXPECT.

## Timing
- One comparison per cycle; no backpressure. The processor is never stalled.
- Latency: done/pass rise on the first clk edge after the cycle in which the final matching store is presented.
- start → busy: 1 cycle.
- Simultaneous start and load_en in IDLE: the write takes effect. The first comparison occurs no earlier than the next cycle, so it sees the new entry.
- Simultaneous final match and timeout expiry: match wins, and the state goes to PASS.
- Simultaneous mismatch and timeout expiry: FAIL wins.
- start asserted in a done state: restart as from IDLE, with the table retained.
- reset mid-RUN: IDLE on the next edge; partial progress is discarded.
- cycles counts RUN cycles only and freezes on entering a done state.

## Test plan
- Load entries 0..2 = {0x10,0xFEFE},{0x14,0x1},{0x18,0x2}; start with count=3; present the three stores on cycles 2, 5, 6 → pass=1 one cycle after the third store, err_index=0, cycles=7.
- Same table; second store has data 0x3 → FAIL, err_index=1, err_addr=0x14, err_data=0x3, pass=0.
- TIMEOUT=20; count=2; present only one matching store → done=1, pass=0 after 20 RUN cycles, err_index=1.
- start with expect_count=0 → pass=1 on the next cycle, cycles=0.
- Assert reset mid-RUN after one match, then restart with the same table → first check restarts at entry 0 and passes; load_en asserted during RUN leaves the entry unchanged.
- Final matching store on the timeout-expiry cycle → PASS, not TIMEOUT.
